// File: rtl/ghostchip_sound_timer.sv
// CHIP-8 / XO-CHIP delay and sound timers with a 60 Hz tick and a 1-bit speaker.
// Mode 0 plays a fixed square beep; mode 1 plays a 1-bit pattern buffer at a programmable pitch.
module ghostchip_sound_timer #(
    parameter int CLK_HZ        = 4857480,
    parameter int TICK_HZ       = 60,
    parameter int TICK_SRC      = 0,
    parameter int BEEP_HZ       = 440,
    parameter int PATTERN_BYTES = 16,
    parameter int ACC_W         = 24,
    localparam int AW           = (PATTERN_BYTES > 1) ? $clog2(PATTERN_BYTES) : 1
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          vsync,
    input  logic          mode,
    input  logic          dt_we,
    input  logic          st_we,
    input  logic [7:0]    timer_din,
    output logic [7:0]    dt_dout,
    output logic [7:0]    st_dout,
    input  logic          pat_we,
    input  logic [AW-1:0] pat_addr,
    input  logic [7:0]    pat_din,
    input  logic          pitch_we,
    output logic          tick,
    output logic          beep,
    output logic          spkr
);

    localparam int IW    = $clog2(PATTERN_BYTES * 8);
    localparam int SW    = ((ACC_W > 9) ? ACC_W : 9) + 1;
    localparam int DIV_N = CLK_HZ / TICK_HZ;
    localparam int HALF  = CLK_HZ / (2 * BEEP_HZ);

    logic [7:0]       dt;
    logic [7:0]       st;
    logic [7:0]       dt_next;
    logic [7:0]       st_next;
    logic             sound_start;
    logic [7:0]       pitch;
    logic [7:0]       pat_mem [PATTERN_BYTES];
    logic [IW-1:0]    idx;
    logic [ACC_W-1:0] acc;
    logic [SW-1:0]    acc_sum;
    logic             carry;
    logic [31:0]      sq_cnt;
    logic             phase;
    logic [AW-1:0]    byte_sel;
    logic [7:0]       cur_byte;
    logic             cur_bit;

    generate
        if (TICK_SRC == 0) begin : g_vsync
            logic vsync_q;
            logic tick_q;
            // vsync_q tracks vsync during reset too, so a vsync already high
            // at release is not mistaken for a rising edge.
            always_ff @(posedge clk) begin
                vsync_q <= vsync;
                if (!reset) begin
                    tick_q <= 1'b0;
                end else begin
                    tick_q <= vsync & ~vsync_q;
                end
            end
            assign tick = tick_q;
        end else begin : g_div
            logic [31:0] div_cnt;
            wire unused_vsync = vsync;
            always_ff @(posedge clk) begin
                if (!reset) begin
                    div_cnt <= 32'd0;
                end else if (div_cnt == 32'(DIV_N - 1)) begin
                    div_cnt <= 32'd0;
                end else begin
                    div_cnt <= div_cnt + 32'd1;
                end
            end
            assign tick = (div_cnt == 32'(DIV_N - 1));
        end
    endgenerate

    // A cpu write wins over a same-cycle tick decrement.
    always_comb begin
        dt_next = dt;
        st_next = st;
        if (dt_we) begin
            dt_next = timer_din;
        end else if (tick && (dt != 8'd0)) begin
            dt_next = dt - 8'd1;
        end
        if (st_we) begin
            st_next = timer_din;
        end else if (tick && (st != 8'd0)) begin
            st_next = st - 8'd1;
        end
    end

    assign sound_start = (st == 8'd0) && (st_next != 8'd0);
    assign acc_sum     = SW'(acc) + SW'(pitch) + SW'(1);
    assign carry       = |acc_sum[SW-1:ACC_W];
    assign byte_sel    = AW'(idx >> 3);
    assign cur_byte    = pat_mem[byte_sel];
    assign cur_bit     = cur_byte[3'd7 - idx[2:0]];

    always_ff @(posedge clk) begin
        if (!reset) begin
            dt     <= 8'd0;
            st     <= 8'd0;
            beep   <= 1'b0;
            pitch  <= 8'd64;
            idx    <= '0;
            acc    <= '0;
            sq_cnt <= 32'd0;
            phase  <= 1'b0;
            spkr   <= 1'b0;
            for (int i = 0; i < PATTERN_BYTES; i++) begin
                pat_mem[i] <= 8'h00;
            end
        end else begin
            dt   <= dt_next;
            st   <= st_next;
            beep <= (st_next != 8'd0);
            if (pat_we && (int'(pat_addr) < PATTERN_BYTES)) begin
                pat_mem[pat_addr] <= pat_din;
            end
            if (pitch_we) begin
                pitch <= pat_din;
            end
            // Both generators run regardless of mode so a mode switch mid-sound
            // picks up where the other generator currently is.
            if (sound_start) begin
                idx    <= '0;
                acc    <= '0;
                sq_cnt <= 32'd0;
                phase  <= 1'b0;
            end else begin
                acc <= acc_sum[ACC_W-1:0];
                if (carry) begin
                    idx <= idx + IW'(1);
                end
                if (sq_cnt == 32'(HALF - 1)) begin
                    sq_cnt <= 32'd0;
                    phase  <= ~phase;
                end else begin
                    sq_cnt <= sq_cnt + 32'd1;
                end
            end
            spkr <= (st != 8'd0) && (mode ? cur_bit : phase);
        end
    end

    assign dt_dout = dt;
    assign st_dout = st;

endmodule

// File: tb/tb_ghostchip_sound_timer.sv
// Directed bench: u_a uses the internal 60 Hz divider, u_b uses vsync ticks with
// a 1 kHz beep and a 4-bit accumulator so pattern playback runs at one bit per cycle.
module tb_ghostchip_sound_timer;

    logic       clk = 1'b0;
    logic       reset, vsync, mode, dt_we, st_we, pat_we, pitch_we;
    logic [7:0] timer_din, pat_din;
    logic [3:0] pat_addr;
    logic [7:0] a_dt, a_st, b_dt, b_st;
    logic       a_tick, a_beep, a_spkr, b_tick, b_beep, b_spkr;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    ghostchip_sound_timer #(
        .CLK_HZ(6000), .TICK_HZ(60), .TICK_SRC(1), .BEEP_HZ(440),
        .PATTERN_BYTES(16), .ACC_W(24)
    ) u_a (
        .clk(clk), .reset(reset), .vsync(vsync), .mode(mode),
        .dt_we(dt_we), .st_we(st_we), .timer_din(timer_din),
        .dt_dout(a_dt), .st_dout(a_st),
        .pat_we(pat_we), .pat_addr(pat_addr), .pat_din(pat_din), .pitch_we(pitch_we),
        .tick(a_tick), .beep(a_beep), .spkr(a_spkr)
    );

    ghostchip_sound_timer #(
        .CLK_HZ(8000), .TICK_HZ(60), .TICK_SRC(0), .BEEP_HZ(1000),
        .PATTERN_BYTES(16), .ACC_W(4)
    ) u_b (
        .clk(clk), .reset(reset), .vsync(vsync), .mode(mode),
        .dt_we(dt_we), .st_we(st_we), .timer_din(timer_din),
        .dt_dout(b_dt), .st_dout(b_st),
        .pat_we(pat_we), .pat_addr(pat_addr), .pat_din(pat_din), .pitch_we(pitch_we),
        .tick(b_tick), .beep(b_beep), .spkr(b_spkr)
    );

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        vsync = 0; mode = 0; dt_we = 0; st_we = 0; pat_we = 0; pitch_we = 0;
        timer_din = 0; pat_din = 0; pat_addr = 0;
    endtask

    task automatic apply_reset();
        reset = 0;
        clear_inputs();
        cyc();
        cyc();
        reset = 1;
    endtask

    task automatic wait_tick_a(output int n);
        n = 0;
        while (a_tick !== 1'b1 && n < 300) begin
            cyc();
            n++;
        end
        if (n >= 300) begin
            checks++; failures++;
            $display("FAIL tick_timeout: no tick within %0d cycles", n);
        end
    endtask

    task automatic test_reset();
        reset = 0;
        clear_inputs();
        cyc();
        cyc();
        checks++; if (a_dt !== 8'd0 || a_st !== 8'd0) begin failures++; $display("FAIL reset_a_timers: dt=%0d st=%0d want 0 0", a_dt, a_st); end
        checks++; if (a_tick !== 1'b0 || a_beep !== 1'b0 || a_spkr !== 1'b0) begin failures++; $display("FAIL reset_a_bits: tick=%b beep=%b spkr=%b want 000", a_tick, a_beep, a_spkr); end
        checks++; if (b_dt !== 8'd0 || b_st !== 8'd0) begin failures++; $display("FAIL reset_b_timers: dt=%0d st=%0d want 0 0", b_dt, b_st); end
        checks++; if (b_tick !== 1'b0 || b_beep !== 1'b0 || b_spkr !== 1'b0) begin failures++; $display("FAIL reset_b_bits: tick=%b beep=%b spkr=%b want 000", b_tick, b_beep, b_spkr); end
        reset = 1;
    endtask

    task automatic test_div_tick();
        int n;
        logic [7:0] exp_dt;
        apply_reset();
        dt_we = 1; timer_din = 8'd3;
        cyc();
        dt_we = 0;
        checks++; if (a_dt !== 8'd3) begin failures++; $display("FAIL dt_load: got %0d want 3", a_dt); end
        for (int i = 0; i < 4; i++) begin
            wait_tick_a(n);
            if (i > 0) begin
                checks++; if (n + 1 != 100) begin failures++; $display("FAIL tick_period: got %0d want 100", n + 1); end
            end
            cyc();
            exp_dt = (i < 3) ? 8'(2 - i) : 8'd0;
            checks++; if (a_tick !== 1'b0) begin failures++; $display("FAIL tick_width: tick=%b want 0", a_tick); end
            checks++; if (a_dt !== exp_dt) begin failures++; $display("FAIL dt_dec%0d: got %0d want %0d", i, a_dt, exp_dt); end
        end
    endtask

    task automatic test_write_priority();
        int n;
        apply_reset();
        st_we = 1; timer_din = 8'd9;
        cyc();
        st_we = 0;
        wait_tick_a(n);
        st_we = 1; timer_din = 8'd5;
        cyc();
        st_we = 0;
        checks++; if (a_st !== 8'd5) begin failures++; $display("FAIL st_write_on_tick: got %0d want 5", a_st); end
        checks++; if (a_beep !== 1'b1) begin failures++; $display("FAIL beep_on: got %b want 1", a_beep); end
        wait_tick_a(n);
        cyc();
        checks++; if (a_st !== 8'd4) begin failures++; $display("FAIL st_next_tick: got %0d want 4", a_st); end
    endtask

    task automatic test_vsync_tick();
        int ticks = 0;
        int run = 0;
        int maxw = 0;
        apply_reset();
        for (int p = 0; p < 3; p++) begin
            vsync = 1;
            for (int c = 0; c < 10; c++) begin
                cyc();
                if (c == 0) begin
                    checks++; if (b_tick !== 1'b1) begin failures++; $display("FAIL tick_position%0d: got %b want 1", p, b_tick); end
                end
                if (b_tick === 1'b1) begin ticks++; run++; end else run = 0;
                if (run > maxw) maxw = run;
            end
            vsync = 0;
            for (int c = 0; c < 10; c++) begin
                cyc();
                if (b_tick === 1'b1) begin ticks++; run++; end else run = 0;
                if (run > maxw) maxw = run;
            end
        end
        checks++; if (ticks != 3) begin failures++; $display("FAIL vsync_tick_count: got %0d want 3", ticks); end
        checks++; if (maxw != 1) begin failures++; $display("FAIL vsync_tick_width: got %0d want 1", maxw); end
        reset = 0; vsync = 1;
        cyc();
        cyc();
        reset = 1;
        ticks = 0;
        for (int c = 0; c < 20; c++) begin
            cyc();
            if (b_tick === 1'b1) ticks++;
        end
        checks++; if (ticks != 0) begin failures++; $display("FAIL vsync_high_at_release: got %0d ticks want 0", ticks); end
        vsync = 0;
    endtask

    task automatic test_square();
        logic exp;
        int ones = 0;
        apply_reset();
        mode = 0;
        st_we = 1; timer_din = 8'd2;
        cyc();
        st_we = 0;
        checks++; if (b_st !== 8'd2 || b_beep !== 1'b1 || b_spkr !== 1'b0) begin failures++; $display("FAIL sq_start: st=%0d beep=%b spkr=%b want 2 1 0", b_st, b_beep, b_spkr); end
        for (int k = 1; k <= 16; k++) begin
            cyc();
            exp = (((k - 1) / 4) % 2) == 1;
            checks++; if (b_spkr !== exp) begin failures++; $display("FAIL sq_wave%0d: got %b want %b", k, b_spkr, exp); end
        end
        vsync = 1; cyc(); vsync = 0; cyc();
        checks++; if (b_st !== 8'd1 || b_beep !== 1'b1) begin failures++; $display("FAIL sq_st1: st=%0d beep=%b want 1 1", b_st, b_beep); end
        vsync = 1; cyc(); vsync = 0; cyc();
        checks++; if (b_st !== 8'd0 || b_beep !== 1'b0) begin failures++; $display("FAIL sq_st0: st=%0d beep=%b want 0 0", b_st, b_beep); end
        cyc();
        checks++; if (b_spkr !== 1'b0) begin failures++; $display("FAIL sq_silent: got %b want 0", b_spkr); end
        for (int k = 0; k < 8; k++) begin
            cyc();
            if (b_spkr === 1'b1) ones++;
        end
        checks++; if (ones != 0) begin failures++; $display("FAIL sq_stays_silent: got %0d ones want 0", ones); end
    endtask

    task automatic test_pattern();
        logic [7:0] pat = 8'hA5;
        int ones = 0;
        apply_reset();
        mode = 1;
        pat_we = 1; pat_addr = 4'd0; pat_din = pat;
        cyc();
        pat_we = 0; pitch_we = 1; pat_din = 8'd15;
        cyc();
        pitch_we = 0;
        st_we = 1; timer_din = 8'd1;
        cyc();
        st_we = 0;
        for (int k = 1; k <= 8; k++) begin
            cyc();
            checks++; if (b_spkr !== pat[8 - k]) begin failures++; $display("FAIL pat_bit%0d: got %b want %b", k - 1, b_spkr, pat[8 - k]); end
        end
        for (int k = 9; k <= 128; k++) begin
            cyc();
            if (b_spkr === 1'b1) ones++;
        end
        checks++; if (ones != 0) begin failures++; $display("FAIL pat_zero_bytes: got %0d ones want 0", ones); end
        for (int k = 129; k <= 136; k++) begin
            cyc();
            checks++; if (b_spkr !== pat[136 - k]) begin failures++; $display("FAIL pat_wrap%0d: got %b want %b", k - 129, b_spkr, pat[136 - k]); end
        end
        pat_we = 1; pat_addr = 4'd1; pat_din = 8'hFF;
        cyc();
        pat_we = 0;
        checks++; if (b_spkr !== 1'b0) begin failures++; $display("FAIL live_write_old: got %b want 0", b_spkr); end
        cyc();
        checks++; if (b_spkr !== 1'b1) begin failures++; $display("FAIL live_write_new: got %b want 1", b_spkr); end
        mode = 0;
        cyc();
        checks++; if (b_spkr !== 1'b0) begin failures++; $display("FAIL mode_sw_a: got %b want 0", b_spkr); end
        cyc();
        checks++; if (b_spkr !== 1'b0) begin failures++; $display("FAIL mode_sw_b: got %b want 0", b_spkr); end
        cyc();
        checks++; if (b_spkr !== 1'b1) begin failures++; $display("FAIL mode_sw_c: got %b want 1", b_spkr); end
        mode = 1;
        cyc();
        checks++; if (b_spkr !== 1'b1) begin failures++; $display("FAIL mode_back: got %b want 1", b_spkr); end
    endtask

    task automatic test_reset_mid();
        int ones = 0;
        apply_reset();
        mode = 1;
        for (int i = 0; i < 16; i++) begin
            pat_we = 1; pat_addr = 4'(i); pat_din = 8'hFF;
            cyc();
        end
        pat_we = 0;
        pitch_we = 1; pat_din = 8'd200;
        cyc();
        pitch_we = 0;
        st_we = 1; timer_din = 8'd10;
        cyc();
        st_we = 0;
        cyc();
        cyc();
        checks++; if (b_spkr !== 1'b1 || b_st !== 8'd10) begin failures++; $display("FAIL mid_setup: spkr=%b st=%0d want 1 10", b_spkr, b_st); end
        checks++; if (u_b.pitch !== 8'd200) begin failures++; $display("FAIL mid_pitch_set: got %0d want 200", u_b.pitch); end
        reset = 0;
        cyc();
        checks++; if (b_st !== 8'd0 || b_beep !== 1'b0 || b_spkr !== 1'b0) begin failures++; $display("FAIL mid_reset_out: st=%0d beep=%b spkr=%b want 0 0 0", b_st, b_beep, b_spkr); end
        checks++; if (u_b.pitch !== 8'd64) begin failures++; $display("FAIL mid_reset_pitch: got %0d want 64", u_b.pitch); end
        reset = 1;
        st_we = 1; timer_din = 8'd1;
        cyc();
        st_we = 0;
        checks++; if (b_beep !== 1'b1) begin failures++; $display("FAIL mid_replay_beep: got %b want 1", b_beep); end
        for (int k = 0; k < 130; k++) begin
            cyc();
            if (b_spkr === 1'b1) ones++;
        end
        checks++; if (ones != 0) begin failures++; $display("FAIL mid_reset_pattern: got %0d ones want 0", ones); end
    endtask

    initial begin
        reset = 0;
        clear_inputs();
        test_reset();
        test_div_tick();
        test_write_priority();
        test_vsync_tick();
        test_square();
        test_pattern();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
